// File: rtl/seven_seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_capture
// Brief    : Captures a multiplexed active-low seven-segment bus, filters
//            glitches, decodes digits and reassembles 16-bit frames.
// Revision : 1.0
// ============================================================================
module seven_seg_capture #(
    parameter int STABLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  g_to_a,
    input  logic [3:0]  an,
    output logic [15:0] data,
    output logic        frame_valid,
    output logic        changed,
    output logic        bad_an,
    output logic        bad_seg
);

    localparam logic [7:0]  c_stable   = 8'(STABLE_CYCLES);
    localparam logic [7:0]  c_run_max  = 8'hFF;
    localparam logic [3:0]  c_an_blank = 4'b1111;
    localparam logic [10:0] c_pat_idle = 11'h7FF;

    // Returns {valid, nibble} for an active-low gfedcba code.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        r = 5'b0_0000;
        case (seg)
            7'b1000000: r = {1'b1, 4'h0};
            7'b1111001: r = {1'b1, 4'h1};
            7'b0100100: r = {1'b1, 4'h2};
            7'b0110000: r = {1'b1, 4'h3};
            7'b0011001: r = {1'b1, 4'h4};
            7'b0010010: r = {1'b1, 4'h5};
            7'b0000010: r = {1'b1, 4'h6};
            7'b1111000: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0010000: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b0000011: r = {1'b1, 4'hB};
            7'b1000110: r = {1'b1, 4'hC};
            7'b0100001: r = {1'b1, 4'hD};
            7'b0000110: r = {1'b1, 4'hE};
            7'b0001110: r = {1'b1, 4'hF};
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    logic [10:0] pat_q, pat_d;
    logic [7:0]  run_q, run_d;
    logic        fresh_q, fresh_d;
    logic [15:0] store_q, store_d;
    logic [3:0]  seen_q, seen_d;
    logic [15:0] data_q, data_d;
    logic        frame_valid_q, frame_valid_d;
    logic        changed_q, changed_d;
    logic        bad_an_q, bad_an_d;
    logic        bad_seg_q, bad_seg_d;

    logic        w_accept;
    logic        w_an_blank;
    logic        w_an_onehot;
    logic [1:0]  w_an_idx;
    logic [4:0]  w_seg_dec;
    logic        w_seg_ok;
    logic [3:0]  w_seg_nib;
    logic        w_digit_ok;
    logic [3:0]  w_digit_we;
    logic [3:0]  w_seen_merge;
    logic [15:0] w_frame_word;

    // fresh_q marks that the run counter advanced or restarted on the last
    // edge, so a saturated run at 255 cannot be accepted twice.
    always_comb begin
        pat_d   = {an, g_to_a};
        run_d   = run_q;
        fresh_d = 1'b0;
        if (pat_d != pat_q) begin
            run_d   = 8'd1;
            fresh_d = 1'b1;
        end else if (run_q != c_run_max) begin
            run_d   = run_q + 8'd1;
            fresh_d = 1'b1;
        end
    end

    assign w_accept   = fresh_q && (run_q == c_stable);
    assign w_an_blank = (pat_q[10:7] == c_an_blank);
    assign w_seg_dec  = seg_decode(pat_q[6:0]);
    assign w_seg_ok   = w_seg_dec[4];
    assign w_seg_nib  = w_seg_dec[3:0];

    always_comb begin
        w_an_idx    = 2'd0;
        w_an_onehot = 1'b1;
        case (pat_q[10:7])
            4'b1110: w_an_idx = 2'd0;
            4'b1101: w_an_idx = 2'd1;
            4'b1011: w_an_idx = 2'd2;
            4'b0111: w_an_idx = 2'd3;
            default: w_an_onehot = 1'b0;
        endcase
    end

    assign w_digit_ok = w_accept && w_an_onehot && w_seg_ok;

    // Candidate store contents with the incoming nibble merged in place.
    for (genvar i = 0; i < 4; i++) begin : g_digit
        assign w_digit_we[i]         = w_digit_ok && (w_an_idx == 2'(i));
        assign w_frame_word[4*i +: 4] = w_digit_we[i] ? w_seg_nib : store_q[4*i +: 4];
    end

    assign w_seen_merge = seen_q | w_digit_we;

    always_comb begin
        store_d       = store_q;
        seen_d        = seen_q;
        data_d        = data_q;
        frame_valid_d = 1'b0;
        changed_d     = 1'b0;
        bad_an_d      = 1'b0;
        bad_seg_d     = 1'b0;
        if (w_accept && !w_an_blank) begin
            if (!w_an_onehot) begin
                bad_an_d = 1'b1;
            end else if (!w_seg_ok) begin
                bad_seg_d = 1'b1;
            end else begin
                store_d = w_frame_word;
                if (w_seen_merge == 4'b1111) begin
                    data_d        = w_frame_word;
                    frame_valid_d = 1'b1;
                    changed_d     = (w_frame_word != data_q);
                    seen_d        = 4'b0000;
                end else begin
                    seen_d = w_seen_merge;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q         <= c_pat_idle;
            run_q         <= 8'd0;
            fresh_q       <= 1'b0;
            store_q       <= 16'h0000;
            seen_q        <= 4'b0000;
            data_q        <= 16'h0000;
            frame_valid_q <= 1'b0;
            changed_q     <= 1'b0;
            bad_an_q      <= 1'b0;
            bad_seg_q     <= 1'b0;
        end else begin
            pat_q         <= pat_d;
            run_q         <= run_d;
            fresh_q       <= fresh_d;
            store_q       <= store_d;
            seen_q        <= seen_d;
            data_q        <= data_d;
            frame_valid_q <= frame_valid_d;
            changed_q     <= changed_d;
            bad_an_q      <= bad_an_d;
            bad_seg_q     <= bad_seg_d;
        end
    end

    assign data        = data_q;
    assign frame_valid = frame_valid_q;
    assign changed     = changed_q;
    assign bad_an      = bad_an_q;
    assign bad_seg     = bad_seg_q;

endmodule
`default_nettype wire
